// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper, frame data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input; INIT is the reset value.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: 8 data bits LSB first, 1 stop bit, one-cycle strobes, no backpressure.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 9600
) (
    input  logic       iCE_CLK,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int N  = clks_per_bit(CLK_HZ, BAUD);
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H - 1);

    generate
        if (N < 4) begin : g_n_check
            $error("uart_rx_framer: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk (iCE_CLK),
        .rst (rst),
        .d   (RX),
        .q   (rx_s)
    );

    uart_state_e state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [2:0]    bit_cnt_d, bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shift_d, shift_q;
    logic [UART_DATA_BITS-1:0] rx_byte_d, rx_byte_q;
    logic rx_d_d, rx_d_q;
    logic rx_valid_d, rx_valid_q;
    logic frame_err_d, frame_err_q;
    logic par_bad;
`ifdef UART_RX_PARITY_EN
    logic par_bad_d, par_bad_q;
    logic parity_err_d, parity_err_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_d_d      = rx_s;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad      = par_bad_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`else
        par_bad = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line stuck low cannot restart a frame.
                if (rx_d_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == N_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == N_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt_q == N_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    frame_err_d = !rx_s;
                    if (rx_s && !par_bad) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad;
`endif
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCE_CLK) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_d_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_d_q      <= rx_d_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomized scoreboard bench for uart_rx_framer at 12 MHz / 115200 baud (N=104).
module tb_uart_rx_framer;

    localparam int N = 104;
    localparam int H = 52;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_frame_err, rx_parity_err;

    uart_rx_framer #(.CLK_HZ(12000000), .BAUD(115200)) dut (
        .iCE_CLK       (clk),
        .rst           (rst),
        .RX            (rx),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] byt;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err || rx_parity_err) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: v=%0b fe=%0b pe=%0b byte=0x%0h at cycle %0d",
                         rx_valid, rx_frame_err, rx_parity_err, rx_byte, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("rx_valid", int'(rx_valid), int'(e.v));
                chk("rx_frame_err", int'(rx_frame_err), int'(e.fe));
                chk("rx_parity_err", int'(rx_parity_err), int'(e.pe));
                chk("rx_byte", int'(rx_byte), int'(e.byt));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
    endtask

    // Sends one frame bit by bit; optionally pulses rst mid data bit 3.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                              input bit do_rst);
        logic bits[$];
        exp_t e;
        logic perr;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR) bits.push_back(pbit);
        bits.push_back(stop);
        perr  = PAR && (pbit != (^d));
        e.v   = stop && !perr;
        e.fe  = !stop;
        e.pe  = perr;
        if (e.v) last_good = d;
        e.byt = last_good;
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < N; k++) begin
                @(posedge clk);
                #1 rx = bits[b];
                if (b == 0 && k == 0 && !do_rst) begin
                    // Pin edge at cyc, two sync stages, H to start sample, then data/parity/stop, +1 register.
                    e.at = cyc + 2 + H + (PAR ? 10 : 9) * N + 1;
                    exp_q.push_back(e);
                end
                if (rst) begin
                    rst = 1'b0;
                    last_good = 8'h00;
                    @(negedge clk);
                    chk("midframe_rst_byte", int'(rx_byte), 0);
                    chk("midframe_rst_valid", int'(rx_valid), 0);
                    chk("midframe_rst_ferr", int'(rx_frame_err), 0);
                end else if (do_rst && b == 4 && k == H) begin
                    rst = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       pbit;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_byte", int'(rx_byte), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_ferr", int'(rx_frame_err), 0);
        chk("reset_perr", int'(rx_parity_err), 0);

        idle(20);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(10);
        hold_low(30);
        idle(200);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(10);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        hold_low(2000);
        idle(200);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(10);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        idle(50);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        if (PAR) begin
            idle(10);
            send_frame(8'h07, 1'b1, 1'b0, 1'b0);
            idle(10);
            send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            idle(stop ? $urandom_range(0, 40) : $urandom_range(2, 40));
            send_frame(d, stop, pbit, 1'b0);
        end

        idle(20);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("outstanding_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
